// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_ctrl_pkg;

   // FSM encoding; code 3 is unused and recovers to idle
   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
   localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

   // Bit counter width for a given operand width
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit full adder from two half adders and an OR for carry-out.
// Latency: combinational.
// Backpressure: none.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s1;
   logic c1;
   logic c2;

   half_adder u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (s1),
      .carry (c1)
   );

   half_adder u_ha1 (
      .a     (s1),
      .b     (cin),
      .sum   (sum),
      .carry (c2)
   );

   // Both half-adder carries can never be high together, so OR is exact
   assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// 1-bit half adder, building block of the shared full adder cell.
// Latency: combinational.
// Backpressure: none.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: accepts a,b, adds LSB-first one bit per clock, returns sum+carry.
// Latency: out_valid rises WIDTH edges after the accepting edge; accept spacing >= WIDTH+2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             busy
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [STATE_W-1:0] state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   sum_sh;
   logic               c;

   logic               s_bit;
   logic               c_nxt;
   logic [WIDTH-1:0]   sum_nxt;

   // The single shared adder cell, fed from the operand LSBs
   full_adder_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (c),
      .sum  (s_bit),
      .cout (c_nxt)
   );

   // Sum shift register input: shift right, new bit enters at the MSB
   always_comb begin
      sum_nxt            = sum_sh >> 1;
      sum_nxt[WIDTH-1]   = s_bit;
   end

   // FSM, counter, shift registers and carry flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         c      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  c     <= 1'b0;
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= sum_nxt;
               c      <= c_nxt;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state == ST_RUN) || (state == ST_DONE);
   assign sum       = sum_sh;
   assign carry     = c;

endmodule
